dcdir_ctl: RTL

DCDIR_CTL -- requirements
Module: dcdir_ctl

---
 rtl/dcdir_pkg.sv | 32 +++
 rtl/dcdir_ctl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dcdir_pkg.sv
// Shared definitions for the directory controller: op codes, entry layout,
// address field positions, FSM state encoding and the tag parity helper.
package dcdir_pkg;

  localparam int IDX_W     = 7;
  localparam int TAG_W     = 20;
  localparam int ENT_W     = 22;
  localparam int VALID_BIT = 21;
  localparam int PAR_BIT   = 20;
  localparam int IDX_LSB   = 5;
  localparam int TAG_LSB   = 12;

  typedef logic [1:0] op_t;
  localparam op_t OP_LOOKUP = 2'b00;
  localparam op_t OP_FILL   = 2'b01;
  localparam op_t OP_INVAL  = 2'b10;
  localparam op_t OP_FLUSH  = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_INIT  = 3'd0;
  localparam state_t ST_IDLE  = 3'd1;
  localparam state_t ST_RD    = 3'd2;
  localparam state_t ST_CMP   = 3'd3;
  localparam state_t ST_WR    = 3'd4;
  localparam state_t ST_SWEEP = 3'd5;
  localparam state_t ST_RSP   = 3'd6;

  function automatic logic tag_parity(input logic [TAG_W-1:0] tag);
    return ^tag;
  endfunction

endpackage

// File: rtl/dcdir_ctl.sv
// Directory controller: clears the tag directory after reset, then serves
// LOOKUP/FILL/INVAL/FLUSH_ALL requests. Optional DCDIR_PARITY_EN adds tag parity.
module dcdir_ctl
  import dcdir_pkg::*;
#(
  parameter int LINES = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_adr,
  output logic             rsp_val,
  output logic             rsp_hit,
  output logic             rsp_perr,
  output logic [IDX_W-1:0] dir_rd_adr,
  input  logic [ENT_W-1:0] dir_rd_dat,
  output logic [3:0]       dir_wr_en,
  output logic [IDX_W-1:0] dir_wr_adr,
  output logic [ENT_W-1:0] dir_wr_dat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  op_t              op_q;
  logic             armed;
  logic             hit_q;
  logic             perr_q;

  logic rd_valid, rd_tag_eq, rd_perr, rd_hit, cmp_wr, wr_par, wr_cyc;
  logic [IDX_W-1:0] adr_mux;

  assign rd_valid  = dir_rd_dat[VALID_BIT];
  assign rd_tag_eq = (dir_rd_dat[TAG_W-1:0] == tag_q);

`ifdef DCDIR_PARITY_EN
  logic unused_bits;
  assign unused_bits = ^req_adr[IDX_LSB-1:0];
  assign rd_perr     = rd_valid && (dir_rd_dat[PAR_BIT] != tag_parity(dir_rd_dat[TAG_W-1:0]));
  assign wr_par      = tag_parity(tag_q);
`else
  logic unused_bits;
  assign unused_bits = ^{req_adr[IDX_LSB-1:0], dir_rd_dat[PAR_BIT]};
  assign rd_perr     = 1'b0;
  assign wr_par      = 1'b0;
`endif

  assign rd_hit = rd_valid && rd_tag_eq && !rd_perr;
  // A corrupt entry, or an INVAL that hit, needs a clearing write before responding.
  assign cmp_wr = rd_perr || (op_q == OP_INVAL && rd_hit);

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      ST_INIT:  if (armed && cnt == LAST_IDX) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (req_val) begin
          case (req_op)
            OP_LOOKUP, OP_INVAL: state_nxt = ST_RD;
            OP_FILL:             state_nxt = ST_WR;
            default:             state_nxt = ST_SWEEP;
          endcase
        end
      end
      ST_RD:    state_nxt = ST_CMP;
      ST_CMP:   state_nxt = cmp_wr ? ST_WR : ST_IDLE;
      ST_WR:    state_nxt = ST_RSP;
      ST_SWEEP: if (cnt == LAST_IDX) state_nxt = ST_RSP;
      ST_RSP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      cnt    <= '0;
      idx_q  <= '0;
      tag_q  <= '0;
      op_q   <= OP_LOOKUP;
      armed  <= 1'b0;
      hit_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_INIT: begin
          // The first cycle out of reset only arms the clear; writes start next cycle.
          if (!armed)                armed <= 1'b1;
          else if (cnt != LAST_IDX) cnt   <= cnt + 1'b1;
        end
        ST_IDLE: begin
          if (req_val) begin
            op_q   <= req_op;
            idx_q  <= req_adr[IDX_LSB +: IDX_W];
            tag_q  <= req_adr[TAG_LSB +: TAG_W];
            hit_q  <= 1'b0;
            perr_q <= 1'b0;
            cnt    <= '0;
          end
        end
        ST_CMP: begin
          hit_q  <= rd_hit;
          perr_q <= rd_perr;
        end
        ST_SWEEP: if (cnt != LAST_IDX) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Reads and writes share one address so single-port directories work unchanged.
  assign wr_cyc     = (state == ST_INIT && armed) || state == ST_SWEEP || state == ST_WR;
  assign adr_mux    = (state == ST_INIT || state == ST_SWEEP) ? cnt : idx_q;
  assign dir_rd_adr = adr_mux;
  assign dir_wr_adr = adr_mux;
  assign dir_wr_en  = wr_cyc ? 4'b1111 : 4'b0000;
  assign dir_wr_dat = (state == ST_WR && op_q == OP_FILL) ? {1'b1, wr_par, tag_q} : '0;

  assign req_rdy  = (state == ST_IDLE);
  assign rsp_val  = (state == ST_RSP) || (state == ST_CMP && !cmp_wr);
  assign rsp_hit  = (state == ST_RSP) ? hit_q : (state == ST_CMP && !cmp_wr && rd_hit);
  assign rsp_perr = (state == ST_RSP) && perr_q;

endmodule
